// File: rtl/hazard_forward_unit.sv
// Load-use stall and rs/rt forward-select generator for the 5-stage core; shadows EX/MEM destinations. Optional HAZARD_STATS_EN adds stallCount.
// Latency: shouldStall/forwardRs/forwardRt are combinational from ID inputs and shadow state (zero cycles).
// Backpressure: shouldStall holds PC and IF/ID; a load-use hazard costs exactly one bubble.
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int STALL_COUNT_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [REG_ADDR_WIDTH-1:0] idRs,
  input  logic [REG_ADDR_WIDTH-1:0] idRt,
  input  logic                      idUsesRs,
  input  logic                      idUsesRt,
  input  logic                      idWriteRegister,
  input  logic [REG_ADDR_WIDTH-1:0] idDestRegister,
  input  logic                      idIsLoad,
  input  logic                      flush,
  output logic                      shouldStall,
  output logic [1:0]                forwardRs,
`ifdef HAZARD_STATS_EN
  output logic [1:0]                forwardRt,
  output logic [STALL_COUNT_WIDTH-1:0] stallCount
`else
  output logic [1:0]                forwardRt
`endif
);

  localparam logic [1:0] SEL_RF       = 2'b00;
  localparam logic [1:0] SEL_EX_ALU   = 2'b01;
  localparam logic [1:0] SEL_MEM_ALU  = 2'b10;
  localparam logic [1:0] SEL_MEM_LOAD = 2'b11;

  logic                      ex_valid_q,  ex_valid_d;
  logic [REG_ADDR_WIDTH-1:0] ex_dest_q,   ex_dest_d;
  logic                      ex_is_load_q, ex_is_load_d;
  logic                      mem_valid_q, mem_valid_d;
  logic [REG_ADDR_WIDTH-1:0] mem_dest_q,  mem_dest_d;
  logic                      mem_is_load_q, mem_is_load_d;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use_rs, load_use_rt;

  function automatic logic [1:0] sel_source(input logic ex_hit, input logic ex_load,
                                            input logic mem_hit, input logic mem_load);
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_hit) begin
      // A load in EX has no data yet; the stall covers this cycle.
      sel = ex_load ? SEL_RF : SEL_EX_ALU;
    end else if (mem_hit) begin
      sel = mem_load ? SEL_MEM_LOAD : SEL_MEM_ALU;
    end
    return sel;
  endfunction

  always_comb begin
    ex_hit_rs  = idUsesRs && ex_valid_q  && (ex_dest_q  == idRs) && (idRs != '0);
    ex_hit_rt  = idUsesRt && ex_valid_q  && (ex_dest_q  == idRt) && (idRt != '0);
    mem_hit_rs = idUsesRs && mem_valid_q && (mem_dest_q == idRs) && (idRs != '0);
    mem_hit_rt = idUsesRt && mem_valid_q && (mem_dest_q == idRt) && (idRt != '0);

    load_use_rs = ex_hit_rs && ex_is_load_q;
    load_use_rt = ex_hit_rt && ex_is_load_q;
    shouldStall = load_use_rs || load_use_rt;

    forwardRs = sel_source(ex_hit_rs, ex_is_load_q, mem_hit_rs, mem_is_load_q);
    forwardRt = sel_source(ex_hit_rt, ex_is_load_q, mem_hit_rt, mem_is_load_q);
  end

  always_comb begin
    mem_valid_d   = ex_valid_q;
    mem_dest_d    = ex_dest_q;
    mem_is_load_d = ex_is_load_q;

    ex_valid_d   = idWriteRegister && (idDestRegister != '0) && !shouldStall && !flush;
    ex_dest_d    = ex_valid_d ? idDestRegister : '0;
    ex_is_load_d = ex_valid_d && idIsLoad;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ex_valid_q    <= 1'b0;
      ex_dest_q     <= '0;
      ex_is_load_q  <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_dest_q    <= '0;
      mem_is_load_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_dest_q     <= ex_dest_d;
      ex_is_load_q  <= ex_is_load_d;
      mem_valid_q   <= mem_valid_d;
      mem_dest_q    <= mem_dest_d;
      mem_is_load_q <= mem_is_load_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (shouldStall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount = stall_count_q;
`else
  logic unused_stats_width;
  assign unused_stats_width = (STALL_COUNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed table of MIPS ID-stage instructions plus hand sequences for async reset mid-run/mid-stall.
module tb_hazard_forward_unit;

  logic       clock = 1'b0;
  logic       resetN;
  logic [4:0] idRs, idRt, idDestRegister;
  logic       idUsesRs, idUsesRt, idWriteRegister, idIsLoad, flush;
  logic       shouldStall;
  logic [1:0] forwardRs, forwardRt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_forward_unit #(.REG_ADDR_WIDTH(5), .STALL_COUNT_WIDTH(32)) dut (
    .clock(clock), .resetN(resetN),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idWriteRegister(idWriteRegister), .idDestRegister(idDestRegister),
    .idIsLoad(idIsLoad), .flush(flush),
    .shouldStall(shouldStall), .forwardRs(forwardRs),
`ifdef HAZARD_STATS_EN
    .forwardRt(forwardRt), .stallCount(stall_count)
`else
    .forwardRt(forwardRt)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, dest;
    logic       uses_rs, uses_rt, wr, is_load, fl;
    logic       exp_stall;
    logic [1:0] exp_frs, exp_frt;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                       input logic wr, input logic [4:0] dest, input logic ld, input logic fl);
    idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut;
    idWriteRegister = wr; idDestRegister = dest; idIsLoad = ld; flush = fl;
  endtask

  task automatic add_vec(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic ut, input logic wr, input logic [4:0] dest,
                         input logic ld, input logic fl, input logic st,
                         input logic [1:0] frs, input logic [1:0] frt, input int cnt);
    vec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.uses_rs = ur; v.uses_rt = ut; v.wr = wr;
    v.dest = dest; v.is_load = ld; v.fl = fl; v.exp_stall = st;
    v.exp_frs = frs; v.exp_frt = frt; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string nm, input logic st, input logic [1:0] frs, input logic [1:0] frt);
    chk({nm, ".stall"}, {31'd0, shouldStall}, {31'd0, st});
    chk({nm, ".fwdRs"}, {30'd0, forwardRs}, {30'd0, frs});
    chk({nm, ".fwdRt"}, {30'd0, forwardRt}, {30'd0, frt});
  endtask

  initial begin
    //        name          rs  rt  urs urt wr dest ld fl  stall frs    frt  cnt
    add_vec("add3",         1,  2,  1,  1,  1, 3,  0, 0,  0, 2'b00, 2'b00, 0);
    add_vec("sub_ex_fwd",   3,  5,  1,  1,  1, 4,  0, 0,  0, 2'b01, 2'b00, 0);
    add_vec("add3_again",   1,  2,  1,  1,  1, 3,  0, 0,  0, 2'b00, 2'b00, 0);
    add_vec("nop",          0,  0,  0,  0,  0, 0,  0, 0,  0, 2'b00, 2'b00, 0);
    add_vec("sub_mem_fwd",  3,  5,  1,  1,  1, 4,  0, 0,  0, 2'b10, 2'b00, 0);
    add_vec("lw7",          1,  7,  1,  0,  1, 7,  1, 0,  0, 2'b00, 2'b00, 0);
    add_vec("add8_stall",   7,  7,  1,  1,  1, 8,  0, 0,  1, 2'b00, 2'b00, 0);
    add_vec("add8_memld",   7,  7,  1,  1,  1, 8,  0, 0,  0, 2'b11, 2'b11, 1);
    add_vec("addi5_1",      0,  5,  1,  0,  1, 5,  0, 0,  0, 2'b00, 2'b00, 1);
    add_vec("addi5_2",      0,  5,  1,  0,  1, 5,  0, 0,  0, 2'b00, 2'b00, 1);
    add_vec("add6_ex_prio", 5,  5,  1,  1,  1, 6,  0, 0,  0, 2'b01, 2'b01, 1);
    add_vec("addi0",        0,  0,  1,  0,  1, 0,  0, 0,  0, 2'b00, 2'b00, 1);
    add_vec("add1_r0",      0,  0,  1,  1,  1, 1,  0, 0,  0, 2'b00, 2'b00, 1);
    add_vec("lw9_flush",    2,  9,  1,  0,  1, 9,  1, 1,  0, 2'b00, 2'b00, 1);
    add_vec("beq9_9",       9,  9,  1,  1,  0, 0,  0, 0,  0, 2'b00, 2'b00, 1);
    add_vec("lw10",         2, 10,  1,  0,  1, 10, 1, 0,  0, 2'b00, 2'b00, 1);
    add_vec("stall_flush",  10, 0,  1,  1,  1, 11, 0, 1,  1, 2'b00, 2'b00, 1);
    add_vec("add12_memld",  10, 10, 1,  1,  1, 12, 0, 0,  0, 2'b11, 2'b11, 2);

    resetN = 1'b0;
    drive(3, 3, 1, 1, 1, 4, 0, 0);
    #2;
    chk_outs("reset", 1'b0, 2'b00, 2'b00);
`ifdef HAZARD_STATS_EN
    chk("reset.cnt", stall_count, 32'd0);
`endif
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rs, vecs[i].uses_rt,
            vecs[i].wr, vecs[i].dest, vecs[i].is_load, vecs[i].fl);
      #1;
      chk_outs(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_frs, vecs[i].exp_frt);
`ifdef HAZARD_STATS_EN
      chk({vecs[i].name, ".cnt"}, stall_count, vecs[i].exp_cnt);
`endif
      @(negedge clock);
    end

    // Reset asserted with a valid ALU producer in EX.
    drive(1, 2, 1, 1, 1, 3, 0, 0);
    @(negedge clock);
    drive(3, 3, 1, 1, 1, 4, 0, 0);
    #1;
    chk_outs("pre_rst_fwd", 1'b0, 2'b01, 2'b01);
    resetN = 1'b0;
    #1;
    chk_outs("rst_mid_run", 1'b0, 2'b00, 2'b00);
    @(negedge clock);
    resetN = 1'b1;

    // Reset asserted in the middle of a load-use stall.
    drive(1, 7, 1, 0, 1, 7, 1, 0);
    @(negedge clock);
    drive(7, 7, 1, 1, 1, 8, 0, 0);
    #1;
    chk_outs("pre_rst_stall", 1'b1, 2'b00, 2'b00);
    #2;
    resetN = 1'b0;
    #1;
    chk_outs("rst_mid_stall", 1'b0, 2'b00, 2'b00);
`ifdef HAZARD_STATS_EN
    chk("rst_mid_stall.cnt", stall_count, 32'd0);
`endif
    @(negedge clock);
    resetN = 1'b1;

    // First edge after release advances normally.
    drive(1, 2, 1, 1, 1, 3, 0, 0);
    @(negedge clock);
    drive(3, 5, 1, 1, 1, 4, 0, 0);
    #1;
    chk_outs("post_rst_fwd", 1'b0, 2'b01, 2'b00);
    @(negedge clock);
    drive(6, 3, 1, 1, 1, 9, 0, 0);
    #1;
    chk_outs("post_rst_mem_rt", 1'b0, 2'b00, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It sits beside the decode-stage control unit and takes the decoded register usage and destination of the instruction in ID. It keeps its own shadow copy of the EX and MEM stage destinations. Each cycle it drives the ID-stage stall and the per-operand forwarding selects for rs and rt.

Parameters:
REG_ADDR_WIDTH, 5, register index width; index 0 is hard-wired zero and is never a hazard source.
STALL_COUNT_WIDTH, 32, width of the stall statistics counter; used only when the optional feature is enabled.

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous, active-low reset
idRs  input  REG_ADDR_WIDTH  rs field of the instruction in ID
idRt  input  REG_ADDR_WIDTH  rt field of the instruction in ID
idUsesRs  input  1  instruction in ID reads rs (R-type, immediate ops, loads/stores, branches, JR)
idUsesRt  input  1  instruction in ID reads rt (R-type, SW, BEQ/BNE)
idWriteRegister  input  1  instruction in ID writes a register
idDestRegister  input  REG_ADDR_WIDTH  resolved destination: rt, rd or 31 for JAL
idIsLoad  input  1  instruction in ID is LW
flush  input  1  instruction in ID is squashed this cycle (taken branch/jump redirect)
shouldStall  output  1  hold PC and the IF/ID register; insert a bubble into EX
forwardRs  output  2  rs source select: 00 register file, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
forwardRt  output  2  rt source select, same encoding as forwardRs
stallCount  output  STALL_COUNT_WIDTH  stall cycle counter; exists only with HAZARD_STATS_EN

Behaviour:
- Shadow state consists of six registers:
  - exValid, exDest, exIsLoad: the instruction now in EX.
  - memValid, memDest, memIsLoad: the instruction now in MEM.
- Reset:
  - All valid and isLoad bits go to 0; all dest fields go to 0; stallCount goes to 0.
  - Outputs settle to shouldStall=0, forwardRs=00, forwardRt=00.
  - Reset acts immediately at any point, including mid-stall; the first edge after release advances normally.
- Every rising edge:
  - MEM shadow <= EX shadow, unconditionally.
  - The EX shadow loads from the ID inputs, with the valid bit taken as idWriteRegister && idDestRegister!=0 && !shouldStall && !flush.
  - If the valid bit is 0, the EX shadow becomes a bubble: valid=0, isLoad=0.
- Hazard match per operand X (rs, rt):
  - exHit = idUsesX && exValid && exDest==idX && idX!=0.
  - memHit = idUsesX && memValid && memDest==idX && idX!=0.
- Forward select, combinational, zero latency:
  - exHit && !exIsLoad -> 01.
  - Otherwise memHit && !memIsLoad -> 10.
  - Otherwise memHit && memIsLoad -> 11.
  - Otherwise 00.
  - EX has priority over MEM when both match (youngest producer wins).
- Load-use:
  - exHit && exIsLoad on either operand -> shouldStall=1.
  - The select for that operand is 00 during the stall cycle.
  - The next cycle the load has moved to MEM, giving select 11 and shouldStall=0.
  - A load-use hazard costs exactly 1 stall cycle.
- WB is not forwarded: the register file writes in the first half-cycle and reads in the second.
- shouldStall is combinational from the current shadow state and ID inputs. It has no dependency on flush.
- If flush and shouldStall are both 1:
  - The EX shadow becomes a bubble; the stall still holds PC.
  - Next cycle the load is in MEM, so there is no repeat stall.
- Back-to-back stalls are impossible: after a stall, EX always holds a bubble.

Optional Feature:
HAZARD_STATS_EN.
- Defined:
  - stallCount increments by 1 on every edge where shouldStall=1.
  - It saturates at all-ones and clears on reset.
- Undefined:
  - The stallCount port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: resetN=0 mid-run with exValid=1 -> shouldStall=0, forwardRs=forwardRt=00 immediately, before any clock edge.
- ADD $3,$1,$2 then SUB $4,$3,$5: in the SUB's ID cycle forwardRs=01, forwardRt=00, shouldStall=0. With a NOP inserted between them, forwardRs=10.
- LW $7,0($1) then ADD $8,$7,$7: shouldStall=1 for exactly 1 cycle with forwardRs=forwardRt=00. Next cycle shouldStall=0 and forwardRs=forwardRt=11. With HAZARD_STATS_EN, stallCount=1.
- ADDI $5,$0,1; ADDI $5,$0,2; ADD $6,$5,$5: forwardRs=forwardRt=01 (EX priority over MEM).
- Writes to $0 (ADDI $0,$0,9 then ADD $1,$0,$0): forwardRs=forwardRt=00, shouldStall=0.
- LW $9 in ID with flush=1, then BEQ $9,$9 in ID: exValid=0, so shouldStall=0 and forwardRs=00.
